// File: rtl/typedef_pkg.sv
// Shared bus typedefs for the CPU-side bus slice.
// Address/data widths plus the arbiter state encoding.
package typedef_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] address_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_t;

  // Index width for an N-entry vector, never below 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports: req (N-bit request vector), ptr (search start),
//        onehot (winner), idx (winner index).
// Searches upward from ptr with wrap; all-zero out if req is 0.
module rr_pick
  import typedef_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [N-1:0]          onehot,
  output logic [idx_w(N)-1:0]   idx
);

  localparam int IW = idx_w(N);
  localparam int PW = IW + 1;

  logic [PW-1:0] p;
  logic          found;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    p      = '0;
    for (int k = 0; k < N; k++) begin
      p = {1'b0, ptr} + PW'(k);
      if (p >= PW'(N)) begin
        p = p - PW'(N);
      end
      if (!found && req[p[IW-1:0]]) begin
        found              = 1'b1;
        onehot[p[IW-1:0]]  = 1'b1;
        idx                = p[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: round-robin owner of the CPU-side bus into APB.
// Ports: clk, rst (sync, active-high); req/req_addr/req_data/req_sel
//   from NUM_REQ requesters; gnt/done/err back to them;
//   APBMASTERENABLE/addr/data/CPUSEL to the APB master; CPUREADY back.
// All outputs registered. A watchdog of TIMEOUT_CYCLES BUSY cycles
// aborts a transfer (0 disables it).
module cpu_bus_arbiter
  import typedef_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  address_t           req_addr [NUM_REQ],
  input  data_t              req_data [NUM_REQ],
  input  address_t           req_sel  [NUM_REQ],
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic               APBMASTERENABLE,
  output address_t           addr,
  output data_t              data,
  output address_t           CPUSEL,
  input  logic               CPUREADY
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int TW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam bit WD_ON = (TIMEOUT_CYCLES != 0);

  arb_state_t         state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      owner;
  logic [TW-1:0]      timer;

  logic [NUM_REQ-1:0] win_oh;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      ptr_nxt;
  logic               tmo;

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (win_oh),
    .idx    (win_idx)
  );

  assign tmo = WD_ON && (timer == TLAST);

  // Next search starts just past the owner that completed.
  assign ptr_nxt =
    (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      owner           <= '0;
      timer           <= '0;
      gnt             <= '0;
      done            <= '0;
      err             <= '0;
      APBMASTERENABLE <= 1'b0;
      addr            <= '0;
      data            <= '0;
      CPUSEL          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt             <= win_oh;
            owner           <= win_idx;
            addr            <= req_addr[win_idx];
            data            <= req_data[win_idx];
            CPUSEL          <= req_sel[win_idx];
            APBMASTERENABLE <= 1'b1;
            timer           <= '0;
            state           <= BUSY;
          end
        end
        BUSY: begin
          // CPUREADY has priority over a coincident timeout.
          if (CPUREADY || tmo) begin
            APBMASTERENABLE <= 1'b0;
            done            <= gnt;
            err             <= CPUREADY ? '0 : gnt;
            rr_ptr          <= ptr_nxt;
            state           <= DONE;
          end else if (WD_ON) begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          done  <= '0;
          err   <= '0;
          gnt   <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Testbench for cpu_bus_arbiter: directed scenarios plus a
// randomized run against a transaction-level round-robin model.
module tb_cpu_bus_arbiter;
  import typedef_pkg::*;

  localparam int N = 4;
  localparam int T = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, rst0;
  logic [N-1:0] req;
  address_t     req_addr [N];
  data_t        req_data [N];
  address_t     req_sel  [N];
  logic         ready;

  logic [N-1:0] gnt, done, err;
  logic         en;
  address_t     addr, sel;
  data_t        data;

  logic [N-1:0] gnt0, done0, err0;
  logic         en0;
  address_t     addr0, sel0;
  data_t        data0;

  int total = 0;
  int bad   = 0;

  cpu_bus_arbiter #(
    .NUM_REQ(N), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel),
    .gnt(gnt), .done(done), .err(err),
    .APBMASTERENABLE(en), .addr(addr), .data(data),
    .CPUSEL(sel), .CPUREADY(ready)
  );

  cpu_bus_arbiter #(
    .NUM_REQ(N), .TIMEOUT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst0), .req(req),
    .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel),
    .gnt(gnt0), .done(done0), .err(err0),
    .APBMASTERENABLE(en0), .addr(addr0), .data(data0),
    .CPUSEL(sel0), .CPUREADY(ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst   = 1'b1;
    req   = '0;
    ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst0 = 1'b1; req = '1; ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_addr[i] = 32'h100 + i; req_data[i] = 32'h200 + i;
      req_sel[i]  = 32'(i + 1);
    end
    repeat (3) tick();
    total++;
    if ({en, gnt, done, err} !== '0 || addr !== '0 ||
        data !== '0 || sel !== '0) begin
      bad++;
      $display("FAIL reset_outputs en=%b gnt=%b done=%b err=%b addr=%h want all 0",
               en, gnt, done, err, addr);
    end
    rst = 1'b0;
    tick();
    total++;
    if (en !== 1'b1 || gnt !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_grant en=%b gnt=%b want en=1 gnt=0001", en, gnt);
    end
    total++;
    if (addr !== 32'h100) begin
      bad++;
      $display("FAIL reset_first_addr got=%h want=%h", addr, 32'h100);
    end
    do_reset();
  endtask

  task automatic test_single;
    req_addr[2] = 32'h10; req_data[2] = 32'hA5; req_sel[2] = 32'h2;
    req = 4'b0100;
    tick();
    total++;
    if (en !== 1'b1 || gnt !== 4'b0100 || addr !== 32'h10 ||
        data !== 32'hA5 || sel !== 32'h2) begin
      bad++;
      $display("FAIL single_grant en=%b gnt=%b addr=%h data=%h sel=%h want 1 0100 10 a5 2",
               en, gnt, addr, data, sel);
    end
    req_addr[2] = 32'hdead_beef;
    tick();
    total++;
    if (addr !== 32'h10 || done !== '0) begin
      bad++;
      $display("FAIL addr_frozen addr=%h done=%b want addr=10 done=0", addr, done);
    end
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++;
    if (done !== 4'b0100 || en !== 1'b0 || err !== '0) begin
      bad++;
      $display("FAIL single_done done=%b en=%b err=%b want 0100 0 0000", done, en, err);
    end
    req = '0;
    tick();
    total++;
    if (done !== '0 || gnt !== '0) begin
      bad++;
      $display("FAIL single_pulse done=%b gnt=%b want 0 0", done, gnt);
    end
    do_reset();
  endtask

  task automatic test_round_robin;
    logic [N-1:0] oh;
    req = '1;
    for (int k = 0; k < 5; k++) begin
      oh = N'(1) << (k % N);
      tick();
      total++;
      if (en !== 1'b1 || gnt !== oh) begin
        bad++;
        $display("FAIL rr_grant k=%0d gnt=%b en=%b want gnt=%b en=1", k, gnt, en, oh);
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      total++;
      if (done !== oh || en !== 1'b0) begin
        bad++;
        $display("FAIL rr_done k=%0d done=%b en=%b want %b 0", k, done, en, oh);
      end
      req = req & ~oh;
      tick();
      total++;
      if (done !== '0 || gnt !== '0) begin
        bad++;
        $display("FAIL rr_idle k=%0d done=%b gnt=%b want 0 0", k, done, gnt);
      end
      req = req | oh;
    end
    do_reset();
  endtask

  task automatic test_timeout;
    int cnt;
    req = 4'b0010;
    tick();
    cnt = 0;
    while (en === 1'b1 && cnt < 20) begin
      cnt++;
      if (cnt == 2) req[2] = 1'b1;
      tick();
    end
    total++;
    if (cnt != T) begin
      bad++;
      $display("FAIL timeout_len got=%0d want=%0d", cnt, T);
    end
    total++;
    if (done !== 4'b0010 || err !== 4'b0010) begin
      bad++;
      $display("FAIL timeout_flags done=%b err=%b want 0010 0010", done, err);
    end
    req[1] = 1'b0;
    tick();
    total++;
    if (done !== '0 || err !== '0) begin
      bad++;
      $display("FAIL timeout_pulse done=%b err=%b want 0 0", done, err);
    end
    tick();
    total++;
    if (gnt !== 4'b0100 || en !== 1'b1) begin
      bad++;
      $display("FAIL timeout_next gnt=%b en=%b want 0100 1", gnt, en);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    req = '0;
    do_reset();
  endtask

  task automatic test_tie;
    req = 4'b0001;
    tick();
    repeat (T - 1) tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++;
    if (done !== 4'b0001 || err !== '0) begin
      bad++;
      $display("FAIL tie_ready_wins done=%b err=%b want 0001 0000", done, err);
    end
    req = '0;
    do_reset();
  endtask

  task automatic test_reset_mid_busy;
    logic seen;
    req = 4'b1000;
    tick();
    tick();
    rst = 1'b1; ready = 1'b1;
    tick();
    total++;
    if ({en, gnt, done, err} !== '0 || addr !== '0 ||
        data !== '0 || sel !== '0) begin
      bad++;
      $display("FAIL midrst_outputs en=%b gnt=%b done=%b err=%b want all 0",
               en, gnt, done, err);
    end
    rst = 1'b0; ready = 1'b0; req = '0;
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (done !== '0 || err !== '0 || en !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL midrst_no_done saw done/err/en after reset want none");
    end
    do_reset();
  endtask

  task automatic test_no_timeout;
    logic seen;
    rst = 1'b1;
    rst0 = 1'b0;
    req = 4'b1000;
    ready = 1'b0;
    tick();
    total++;
    if (en0 !== 1'b1 || gnt0 !== 4'b1000) begin
      bad++;
      $display("FAIL nowd_grant en=%b gnt=%b want 1 1000", en0, gnt0);
    end
    seen = 1'b0;
    repeat (200) begin
      tick();
      if (en0 !== 1'b1 || done0 !== '0 || err0 !== '0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL nowd_abort transfer ended before CPUREADY want held");
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++;
    if (done0 !== 4'b1000 || err0 !== '0 || en0 !== 1'b0) begin
      bad++;
      $display("FAIL nowd_done done=%b err=%b en=%b want 1000 0000 0",
               done0, err0, en0);
    end
    req = '0;
    rst0 = 1'b1;
    do_reset();
  endtask

  task automatic test_random;
    logic [N-1:0] pend, oh;
    int           mptr, w, d, j;
    bit           fin;
    address_t     ea, es;
    data_t        ed;
    pend = '0;
    mptr = 0;
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) pend[i] = 1'b1;
        req_addr[i] = $urandom; req_data[i] = $urandom;
        req_sel[i]  = $urandom;
      end
      if (pend == '0) pend[$urandom_range(0, N - 1)] = 1'b1;
      req = pend;
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && pend[(mptr + k) % N]) w = (mptr + k) % N;
      end
      oh = N'(1) << w;
      ea = req_addr[w]; ed = req_data[w]; es = req_sel[w];
      tick();
      total++;
      if (en !== 1'b1 || gnt !== oh || addr !== ea ||
          data !== ed || sel !== es) begin
        bad++;
        $display("FAIL rand_grant t=%0d gnt=%b en=%b addr=%h want gnt=%b en=1 addr=%h",
                 t, gnt, en, addr, oh, ea);
      end
      d = $urandom_range(0, 11);
      j = 0;
      fin = 1'b0;
      while (!fin) begin
        ready = (j == d);
        for (int i = 0; i < N; i++) begin
          req_addr[i] = $urandom; req_data[i] = $urandom;
          if (!pend[i] && $urandom_range(0, 4) == 0) begin
            pend[i] = 1'b1;
            req[i]  = 1'b1;
          end
        end
        if ($urandom_range(0, 3) == 0) req[w] = 1'b0;
        tick();
        ready = 1'b0;
        total++;
        if (j == d || j == T - 1) begin
          fin = 1'b1;
          if (done !== oh || err !== ((j == d) ? '0 : oh) ||
              en !== 1'b0 || gnt !== oh) begin
            bad++;
            $display("FAIL rand_done t=%0d d=%0d done=%b err=%b en=%b want done=%b err=%b",
                     t, d, done, err, en, oh, (j == d) ? '0 : oh);
          end
        end else if (en !== 1'b1 || done !== '0 || addr !== ea) begin
          bad++;
          $display("FAIL rand_busy t=%0d j=%0d en=%b done=%b addr=%h want 1 0 %h",
                   t, j, en, done, addr, ea);
        end
        j++;
      end
      pend[w] = 1'b0;
      req     = pend;
      mptr    = (w + 1) % N;
      tick();
      total++;
      if (gnt !== '0 || done !== '0 || err !== '0 || en !== 1'b0) begin
        bad++;
        $display("FAIL rand_turnaround t=%0d gnt=%b done=%b err=%b en=%b want 0",
                 t, gnt, done, err, en);
      end
    end
    req = '0;
    do_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rst0 = 1'b1; req = '0; ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_addr[i] = '0; req_data[i] = '0; req_sel[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_tie();
    test_reset_mid_busy();
    test_no_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
